// File: rtl/dac_ramp_sequencer_pkg.sv
// Shared types and constants for the DAC ramp sequencer: FSM encoding,
// default gain precision and sample width.
package dac_ramp_sequencer_pkg;

    localparam int FRAC_W_DEF = 16;
    localparam int SAMPLE_W   = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

endpackage

// File: rtl/dac_ramp_sequencer_if.sv
// Sample stream between the DAC composer and the ramp sequencer.
interface dac_ramp_sequencer_if;
    import dac_ramp_sequencer_pkg::*;

    logic signed [SAMPLE_W-1:0] signal_in;
    logic                       signal_in_valid;
    logic signed [SAMPLE_W-1:0] signal_out;
    logic                       signal_valid;

    modport master (
        output signal_in, signal_in_valid,
        input  signal_out, signal_valid
    );

    modport slave (
        input  signal_in, signal_in_valid,
        output signal_out, signal_valid
    );
endinterface

// File: rtl/dac_ramp_sequencer_gain_mult.sv
// Two-stage signed sample x unsigned gain multiply, arithmetic shift by FRAC_W.
module ramp_gain_mult
    import dac_ramp_sequencer_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [FRAC_W:0]     gain,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out
);
    localparam int STAGES = 2;
    localparam int PROD_W = SAMPLE_W + FRAC_W + 2;

    logic signed [PROD_W-1:0] prod;
    logic        [STAGES:1]   vld_pipe;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            prod     <= '0;
            out      <= '0;
            vld_pipe <= '0;
        end else begin
            // gain is zero-extended so the product stays signed-correct
            prod     <= PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
            out      <= prod[FRAC_W +: SAMPLE_W];
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: rtl/dac_ramp_sequencer.sv
// Soft start/stop gain ramp for the DAC path: FSM and gain accumulator,
// with the gain applied to the sample stream by ramp_gain_mult.
module dac_ramp_sequencer
    import dac_ramp_sequencer_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           ramp_step,
    dac_ramp_sequencer_if.slave   smp,
    output logic                  disable_dac,
    output state_t                state,
    output logic                  done
);
    // wide enough for gain + step with any FRAC_W
    localparam int SUM_W = FRAC_W + 18;
    localparam logic [FRAC_W:0] UNITY = {1'b1, {FRAC_W{1'b0}}};

    logic [FRAC_W:0]  gain;
    logic [SUM_W-1:0] gain_ext, step_ext, up_sum, dn_diff;
    logic             step_zero, go_up;

    assign gain_ext  = SUM_W'(gain);
    assign step_ext  = SUM_W'(ramp_step);
    assign up_sum    = gain_ext + step_ext;
    assign dn_diff   = gain_ext - step_ext;
    assign step_zero = (ramp_step == '0);
    assign go_up     = start && !stop;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            gain        <= '0;
            disable_dac <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go_up) begin
                        disable_dac <= 1'b0;
                        if (step_zero) begin
                            state <= ACTIVE;
                            gain  <= UNITY;
                        end else begin
                            state <= RAMP_UP;
                        end
                    end
                end
                RAMP_UP: begin
                    if (stop) begin
                        state <= RAMP_DOWN;
                    end else if (smp.signal_in_valid) begin
                        if (up_sum >= SUM_W'(UNITY)) begin
                            gain  <= UNITY;
                            state <= ACTIVE;
                        end else begin
                            gain <= up_sum[FRAC_W:0];
                        end
                    end
                end
                ACTIVE: begin
                    gain <= UNITY;
                    if (stop) state <= RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (go_up) begin
                        // reverse from the current gain; a zero step jumps straight to unity
                        if (step_zero) begin
                            state <= ACTIVE;
                            gain  <= UNITY;
                        end else begin
                            state <= RAMP_UP;
                        end
                    end else if (smp.signal_in_valid) begin
                        if (step_zero || gain_ext <= step_ext) begin
                            gain        <= '0;
                            state       <= IDLE;
                            done        <= 1'b1;
                            disable_dac <= 1'b1;
                        end else begin
                            gain <= dn_diff[FRAC_W:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ramp_gain_mult #(.FRAC_W(FRAC_W)) u_mult (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (smp.signal_in_valid),
        .sample    (smp.signal_in),
        .gain      (gain),
        .out_valid (smp.signal_valid),
        .out       (smp.signal_out)
    );
endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Directed bench for dac_ramp_sequencer: ramp up/down, saturation, abort,
// zero-step and reset-abort scenarios with hand-computed expectations.
module tb_dac_ramp_sequencer;
    import dac_ramp_sequencer_pkg::*;

    logic        clk;
    logic        aresetn;
    logic        start, stop;
    logic [15:0] ramp_step;
    logic        disable_dac, done;
    state_t      state;

    int n_chk  = 0;
    int n_pass = 0;

    dac_ramp_sequencer_if sig_if();

    dac_ramp_sequencer #(.FRAC_W(16)) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start       (start),
        .stop        (stop),
        .ramp_step   (ramp_step),
        .smp         (sig_if),
        .disable_dac (disable_dac),
        .state       (state),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sout();
        return int'(sig_if.signal_out);
    endfunction

    initial begin
        aresetn   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        ramp_step = 16'd16384;
        sig_if.signal_in       = 24'sd1000;
        sig_if.signal_in_valid = 1'b1;
        #13;
        chk("rst_state", int'(state), 0);
        chk("rst_dis", int'(disable_dac), 1);
        chk("rst_vld", int'(sig_if.signal_valid), 0);
        chk("rst_out", sout(), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_gain", int'(dut.gain), 0);
        tick();
        aresetn = 1'b1;
        #2;
        chk("rel_hold", int'(state), 0);

        // ramp up at step 16384, +1000 input
        start = 1'b1;
        tick();
        chk("up_st0", int'(state), 1);
        chk("up_g0", int'(dut.gain), 0);
        chk("up_dis0", int'(disable_dac), 0);
        chk("up_vld0", int'(sig_if.signal_valid), 0);
        start = 1'b0;
        tick();
        chk("up_g1", int'(dut.gain), 16384);
        chk("up_vld1", int'(sig_if.signal_valid), 1);
        chk("up_out1", sout(), 0);
        tick();
        chk("up_g2", int'(dut.gain), 32768);
        tick();
        chk("up_g3", int'(dut.gain), 49152);
        chk("up_out3", sout(), 250);
        tick();
        chk("up_g4", int'(dut.gain), 65536);
        chk("up_act", int'(state), 2);
        chk("up_out4", sout(), 500);
        tick();
        chk("up_out5", sout(), 750);
        tick();
        chk("up_out6", sout(), 1000);

        // ramp down from ACTIVE
        stop = 1'b1;
        tick();
        chk("dn_st", int'(state), 3);
        chk("dn_g0", int'(dut.gain), 65536);
        stop = 1'b0;
        tick();
        chk("dn_g1", int'(dut.gain), 49152);
        tick();
        chk("dn_g2", int'(dut.gain), 32768);
        tick();
        chk("dn_out750", sout(), 750);
        tick();
        chk("dn_idle", int'(state), 0);
        chk("dn_done", int'(done), 1);
        chk("dn_dis", int'(disable_dac), 1);
        chk("dn_out500", sout(), 500);
        tick();
        chk("dn_done_off", int'(done), 0);
        chk("dn_out250", sout(), 250);
        tick();
        chk("dn_out0", sout(), 0);

        // saturating step, full-scale negative at unity
        ramp_step = 16'd40000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("sat_g1", int'(dut.gain), 40000);
        tick();
        chk("sat_g2", int'(dut.gain), 65536);
        chk("sat_act", int'(state), 2);
        sig_if.signal_in = 24'sh800000;
        tick();
        tick();
        chk("sat_neg", sout(), -8388608);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("sat_dn", int'(dut.gain), 25536);
        tick();
        chk("sat_idle", int'(state), 0);
        chk("sat_done", int'(done), 1);
        sig_if.signal_in = 24'sd1000;

        // stop mid ramp-up
        ramp_step = 16'd16384;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ab_g", int'(dut.gain), 32768);
        stop = 1'b1;
        tick();
        chk("ab_st", int'(state), 3);
        chk("ab_hold", int'(dut.gain), 32768);
        stop = 1'b0;
        tick();
        chk("ab_g1", int'(dut.gain), 16384);
        tick();
        chk("ab_g2", int'(dut.gain), 0);
        chk("ab_idle", int'(state), 0);
        chk("ab_done", int'(done), 1);

        // start+stop in IDLE are ignored
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("ss_idle", int'(state), 0);
        chk("ss_dis", int'(disable_dac), 1);
        stop = 1'b0;

        // zero step: straight to unity
        ramp_step = 16'd0;
        tick();
        chk("z_act", int'(state), 2);
        chk("z_gain", int'(dut.gain), 65536);
        start = 1'b0;

        // start+stop in ACTIVE: stop wins
        ramp_step = 16'd16384;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("ss_dn", int'(state), 3);
        chk("ss_g", int'(dut.gain), 65536);
        start = 1'b0;
        stop  = 1'b0;
        sig_if.signal_in_valid = 1'b0;
        tick();
        chk("nv_g", int'(dut.gain), 65536);
        chk("nv_st", int'(state), 3);
        sig_if.signal_in_valid = 1'b1;
        ramp_step = 16'd0;
        tick();
        chk("z_dn_idle", int'(state), 0);
        chk("z_dn_g", int'(dut.gain), 0);
        chk("z_dn_done", int'(done), 1);
        chk("nv_vld", int'(sig_if.signal_valid), 0);
        tick();
        chk("nv_vld1", int'(sig_if.signal_valid), 1);
        chk("z_done_off", int'(done), 0);

        // reset mid ramp-up
        ramp_step = 16'd16384;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ra_g", int'(dut.gain), 32768);
        aresetn = 1'b0;
        #2;
        chk("ra_st", int'(state), 0);
        chk("ra_dis", int'(disable_dac), 1);
        chk("ra_vld", int'(sig_if.signal_valid), 0);
        chk("ra_done", int'(done), 0);
        chk("ra_gain", int'(dut.gain), 0);
        tick();
        aresetn = 1'b1;
        #2;
        chk("ra_done2", int'(done), 0);
        start = 1'b1;
        tick();
        chk("ra_up", int'(state), 1);
        chk("ra_g0", int'(dut.gain), 0);
        chk("ra_vld2", int'(sig_if.signal_valid), 0);
        start = 1'b0;
        tick();
        chk("ra_g1", int'(dut.gain), 16384);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
